// File: rtl/datapath_controller.sv
// Multi-cycle instruction sequencer for the register-bank/ALU datapath.
// Latches one instruction per handshake, decodes it, and walks IDLE->DECODE->EXECUTE->WRITEBACK.
module datapath_controller #(
  parameter int          DATA_W   = 16,
  parameter int          NUM_REGS = 16,
  parameter int          FLAG_W   = 5,
  parameter logic [3:0]  CMP_CODE = 4'hB
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [FLAG_W-1:0]           Flags_in,
  output logic [NUM_REGS-1:0]         wEnable,
  output logic [7:0]                  opcode,
  output logic [$clog2(NUM_REGS)-1:0] Rdest_select,
  output logic [$clog2(NUM_REGS)-1:0] Rsrc_select,
  output logic                        Imm_select,
  output logic [DATA_W-1:0]           Imm_in,
  output logic [FLAG_W-1:0]           psr,
  output logic                        done,
  output logic                        busy
);

  localparam int SEL_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXECUTE,
    WRITEBACK
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;
  logic [3:0]  ir_op;
  logic [3:0]  ir_ext;
  logic        is_reg_form;
  logic        is_cmp;
  logic        is_nop;
  logic        accept;

  assign ir_op       = ir[15:12];
  assign ir_ext      = ir[7:4];
  assign is_reg_form = (ir_op == 4'h0);
  assign is_nop      = (ir == 16'h0000);
  assign is_cmp      = is_reg_form ? (ir_ext == CMP_CODE) : (ir_op == CMP_CODE);
  assign accept      = (state == IDLE) && instr_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IR only changes on an accepted handshake, so the decode stays stable until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= 16'h0000;
    end else if (accept) begin
      ir <= instr;
    end
  end

  // A NOP still completes its writeback slot but must leave the status register alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psr <= '0;
    end else if ((state == WRITEBACK) && !is_nop) begin
      psr <= Flags_in;
    end
  end

  always_comb begin
    Rdest_select = ir[8 +: SEL_W];
    Rsrc_select  = ir[0 +: SEL_W];
    Imm_in       = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    Imm_select   = is_reg_form;
    opcode       = is_reg_form ? {4'h0, ir_ext} : {ir_op, 4'h0};
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wEnable     = '0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        busy       = 1'b1;
        state_next = EXECUTE;
      end
      EXECUTE: begin
        busy       = 1'b1;
        state_next = WRITEBACK;
      end
      WRITEBACK: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
        // Compares only set flags; a NOP writes nothing.
        if (!is_cmp && !is_nop) begin
          wEnable = NUM_REGS'(1) << Rdest_select;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench for datapath_controller: stimulus pushes expectations, a negedge monitor checks them.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  Flags_in = 5'b00000;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select;
  logic [3:0]  Rsrc_select;
  logic        Imm_select;
  logic [15:0] Imm_in;
  logic [4:0]  psr;
  logic        done;
  logic        busy;

  datapath_controller dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Flags_in(Flags_in),
    .wEnable(wEnable),
    .opcode(opcode),
    .Rdest_select(Rdest_select),
    .Rsrc_select(Rsrc_select),
    .Imm_select(Imm_select),
    .Imm_in(Imm_in),
    .psr(psr),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w_enable;
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic        imm_select;
    logic [15:0] imm_in;
    logic [4:0]  psr;
    logic [31:0] done_cycle;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] cycle_cnt = 0;
  logic        psr_pending = 1'b0;
  logic [4:0]  psr_exp = 5'b00000;
  int          waited;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  // Monitor: every completion pops one expectation; psr is checked the cycle after done.
  always @(negedge clk) begin
    if (psr_pending) begin
      checkOutput("psr", 32'(psr), 32'(psr_exp));
      psr_pending = 1'b0;
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("done_cycle", cycle_cnt, mon_e.done_cycle);
        checkOutput("wEnable", 32'(wEnable), 32'(mon_e.w_enable));
        checkOutput("opcode", 32'(opcode), 32'(mon_e.opcode));
        checkOutput("Rdest_select", 32'(Rdest_select), 32'(mon_e.rdest));
        checkOutput("Rsrc_select", 32'(Rsrc_select), 32'(mon_e.rsrc));
        checkOutput("Imm_select", 32'(Imm_select), 32'(mon_e.imm_select));
        checkOutput("Imm_in", 32'(Imm_in), 32'(mon_e.imm_in));
        psr_exp = mon_e.psr;
        psr_pending = 1'b1;
      end
    end else begin
      checkOutput("wEnable_outside_wb", 32'(wEnable), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [15:0] word, input logic [4:0] flags,
                               input logic [15:0] exp_we, input logic [7:0] exp_op,
                               input logic [3:0] exp_rd, input logic [3:0] exp_rs,
                               input logic exp_is, input logic [15:0] exp_imm,
                               input logic [4:0] exp_psr, input bit keep_valid,
                               output int n_wait);
    exp_t e;
    n_wait = 0;
    while (!instr_ready && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    if (!instr_ready) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    instr       = word;
    instr_valid = 1'b1;
    Flags_in    = flags;
    e.w_enable   = exp_we;
    e.opcode     = exp_op;
    e.rdest      = exp_rd;
    e.rsrc       = exp_rs;
    e.imm_select = exp_is;
    e.imm_in     = exp_imm;
    e.psr        = exp_psr;
    e.done_cycle = cycle_cnt + 3;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) instr_valid = 1'b0;
  endtask

  initial begin
    // Reset held low, with a valid instruction that must be ignored.
    instr       = 16'h0355;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_wEnable", 32'(wEnable), 32'd0);
    checkOutput("rst_psr", 32'(psr), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(instr_ready), 32'd1);

    applyStimulus(16'h0355, 5'b00011, 16'h0008, 8'h05, 4'h3, 4'h5, 1'b1, 16'h0055, 5'b00011, 1'b0, waited);
    applyStimulus(16'h52FF, 5'b01000, 16'h0004, 8'h50, 4'h2, 4'hF, 1'b0, 16'hFFFF, 5'b01000, 1'b0, waited);
    applyStimulus(16'h01B2, 5'b10101, 16'h0000, 8'h0B, 4'h1, 4'h2, 1'b1, 16'hFFB2, 5'b10101, 1'b0, waited);
    applyStimulus(16'hB480, 5'b00110, 16'h0000, 8'hB0, 4'h4, 4'h0, 1'b0, 16'hFF80, 5'b00110, 1'b0, waited);
    applyStimulus(16'h0000, 5'b11111, 16'h0000, 8'h00, 4'h0, 4'h0, 1'b1, 16'h0000, 5'b00110, 1'b0, waited);
    applyStimulus(16'h7F01, 5'b00001, 16'h8000, 8'h70, 4'hF, 4'h1, 1'b0, 16'h0001, 5'b00001, 1'b0, waited);

    // Back-to-back with valid held high; the second word sits on the bus while the first runs.
    applyStimulus(16'h0A13, 5'b00010, 16'h0400, 8'h01, 4'hA, 4'h3, 1'b1, 16'h0013, 5'b00010, 1'b1, waited);
    instr = 16'h6C9E;
    checkOutput("b2b_busy_decode", 32'(busy), 32'd1);
    applyStimulus(16'h6C9E, 5'b00100, 16'h1000, 8'h60, 4'hC, 4'hE, 1'b0, 16'hFF9E, 5'b00100, 1'b0, waited);
    checkOutput("b2b_ready_low_cycles", 32'(waited), 32'd3);

    // Reset pulsed during EXECUTE: the instruction must vanish without a write or psr update.
    repeat (4) @(negedge clk);
    checkOutput("pre_abort_ready", 32'(instr_ready), 32'd1);
    instr       = 16'h0355;
    instr_valid = 1'b1;
    Flags_in    = 5'b11011;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_execute", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_wEnable", 32'(wEnable), 32'd0);
    checkOutput("abort_psr_cleared", 32'(psr), 32'd0);
    checkOutput("abort_ready", 32'(instr_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_psr_after", 32'(psr), 32'd0);
    checkOutput("abort_ready_after", 32'(instr_ready), 32'd1);
    checkOutput("abort_busy_after", 32'(busy), 32'd0);

    for (int i = 0; i < 20 && (sb_q.size() != 0 || psr_pending); i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
